// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// The arbiter and its round-robin picker both import this package.
package fifo_wr_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int FIFO_DEPTH    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Width of a counter that must be able to hold the value n itself
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin selector: the search starts just above last_grant
// and wraps modulo NREQ.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   winner,
    output logic            any
);

    int idx;

    // Scan from the farthest candidate to the nearest so the nearest valid
    // requester is the one that sticks.
    always_comb begin
        winner = last_grant;
        any    = 1'b0;
        idx    = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (valid[idx[GW-1:0]]) begin
                winner = idx[GW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ producers share one FIFO write port, with
// bursts capped at MAX_BURST beats (1 beat when the FIFO is past threshold).
//
// state | meaning
// IDLE  | no owner; pick the next round-robin winner when any producer is valid
// XFER  | grant_id owns the FIFO port until last, burst limit, or release
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    fifo_wr,
    output logic [DW-1:0]           fifo_data,
    input  logic                    fifo_full,
    input  logic                    fifo_threshold,
    input  logic                    fifo_overflow,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_ovf
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = cnt_width(MAX_BURST);

    localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] BURST_ONE  = CW'(1);
    localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);

    arb_state_t    state;
    logic [GW-1:0] last_grant;
    logic [CW-1:0] beat_cnt;
    logic          burst_one;

    logic [GW-1:0] pick;
    logic          pick_any;
    logic          g_valid;
    logic          g_last;
    logic          accept;
    logic          at_limit;
    logic          xfer_done;
    logic [CW-1:0] burst_lim;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .winner     (pick),
        .any        (pick_any)
    );

    assign g_valid   = req_valid[grant_id];
    assign g_last    = req_last[grant_id];
    assign burst_lim = burst_one ? BURST_ONE : BURST_MAX;
    assign at_limit  = (beat_cnt + BURST_ONE) == burst_lim;

    // rst_n gates the handshake so nothing is accepted on the reset edge itself
    assign accept    = (state == XFER) && rst_n && g_valid && !fifo_full;
    assign xfer_done = (state == XFER) && (!g_valid || (accept && (g_last || at_limit)));

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = accept;
    end

    assign fifo_wr   = accept;
    assign fifo_data = req_data[int'(grant_id)*DW +: DW];
    assign busy      = (state == XFER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LAST_RESET;
            grant_id   <= '0;
            beat_cnt   <= '0;
            burst_one  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            if (fifo_overflow) begin
                err_ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick;
                        beat_cnt  <= '0;
                        burst_one <= fifo_threshold;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        last_grant <= grant_id;
                        beat_cnt   <= '0;
                        state      <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BURST_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a behavioural 16-deep FIFO behind it.
module tb_fifo_wr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic              fifo_threshold;
    logic              fifo_overflow;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_ovf;

    logic [7:0] fmem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic       fifo_rd;
    logic       drain;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_wr        (fifo_wr),
        .fifo_data      (fifo_data),
        .fifo_full      (fifo_full),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_ovf        (err_ovf)
    );

    wire do_wr = fifo_wr && (fcnt != 5'd16);
    wire do_rd = (fifo_rd || drain) && (fcnt != 5'd0);
    assign fifo_full = (fcnt == 5'd16);

    always @(posedge clk) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (do_wr) begin
                fmem[wp] <= fifo_data;
                wp       <= wp + 4'd1;
            end
            if (do_rd) rp <= rp + 4'd1;
            fcnt <= fcnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int k, input logic [7:0] v);
        req_data[k*DW +: DW] = v;
    endtask

    task automatic clear_inputs();
        req_valid      = '0;
        req_data       = '0;
        req_last       = '0;
        fifo_threshold = 1'b0;
        fifo_overflow  = 1'b0;
        fifo_rd        = 1'b0;
        drain          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        tick();
        #1;
        n_vec++;
        if (req_ready !== 4'h0 || fifo_wr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%h wr=%b, want 0/0", req_ready, fifo_wr);
        end
        n_vec++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b grant=%0d err_ovf=%b, want 0/0/0", busy, grant_id, err_ovf);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_slice(2, 8'h11);
        req_valid = 4'b0100;
        #1;
        n_vec++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy=%b wr=%b, want 0/0", busy, fifo_wr);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_slice(2, 8'(8'h11 + i));
            req_last[2] = (i == 2);
            #1;
            n_vec++;
            if (grant_id !== 2'd2 || fifo_wr !== 1'b1 || req_ready !== 4'b0100 || fifo_data !== 8'(8'h11 + i)) begin
                n_err++;
                $display("FAIL single_beat%0d: grant=%0d wr=%b ready=%h data=%h, want 2/1/4/%h",
                         i, grant_id, fifo_wr, req_ready, fifo_data, 8'(8'h11 + i));
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || grant_id !== 2'd2 || fcnt !== 5'd3) begin
            n_err++;
            $display("FAIL single_done: busy=%b grant=%0d fcnt=%0d, want 0/2/3", busy, grant_id, fcnt);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (fmem[rp] !== 8'(8'h11 + i)) begin
                n_err++;
                $display("FAIL single_readback%0d: got %h want %h", i, fmem[rp], 8'(8'h11 + i));
            end
            fifo_rd = 1'b1;
            tick();
            fifo_rd = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int eg;
        do_reset();
        drain     = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < NREQ; k++) set_slice(k, 8'(8'h40 + k));
        for (int c = 0; c < 25; c++) begin
            #1;
            eg = (c / 5) % 4;
            n_vec++;
            if (c % 5 == 0) begin
                if (fifo_wr !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
                    n_err++;
                    $display("FAIL rr_bubble c%0d: wr=%b busy=%b ready=%h, want 0/0/0", c, fifo_wr, busy, req_ready);
                end
            end else begin
                if (fifo_wr !== 1'b1 || grant_id !== 2'(eg) || fifo_data !== 8'(8'h40 + eg)
                    || req_ready !== 4'(1 << eg)) begin
                    n_err++;
                    $display("FAIL rr_beat c%0d: wr=%b grant=%0d data=%h ready=%h, want 1/%0d/%h/%h",
                             c, fifo_wr, grant_id, fifo_data, req_ready, eg, 8'(8'h40 + eg), 4'(1 << eg));
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_full_stall();
        int sent;
        logic [7:0] popped;
        do_reset();
        req_valid = 4'b0001;
        sent = 0;
        for (int cyc = 0; cyc < 60 && sent < 16; cyc++) begin
            set_slice(0, 8'(8'h80 + sent));
            #1;
            if (fifo_wr) sent++;
            tick();
        end
        n_vec++;
        if (sent !== 16 || fcnt !== 5'd16) begin
            n_err++;
            $display("FAIL full_fill: writes=%0d fcnt=%0d, want 16/16", sent, fcnt);
        end
        set_slice(0, 8'h90);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (fifo_wr !== 1'b0 || err_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL full_stall c%0d: wr=%b err_ovf=%b, want 0/0", c, fifo_wr, err_ovf);
            end
            tick();
        end
        n_vec++;
        if (busy !== 1'b1 || fcnt !== 5'd16 || fifo_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_hold: busy=%b fcnt=%0d full=%b, want 1/16/1", busy, fcnt, fifo_full);
        end
        popped  = fmem[rp];
        fifo_rd = 1'b1;
        #1;
        n_vec++;
        if (fifo_wr !== 1'b0) begin
            n_err++;
            $display("FAIL full_pop_cycle: wr=%b want 0", fifo_wr);
        end
        tick();
        fifo_rd = 1'b0;
        #1;
        n_vec++;
        if (popped !== 8'h80 || fifo_wr !== 1'b1 || fifo_data !== 8'h90 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL full_beat17: popped=%h wr=%b data=%h grant=%0d, want 80/1/90/0",
                     popped, fifo_wr, fifo_data, grant_id);
        end
        tick();
        req_valid = '0;
        #1;
        n_vec++;
        if (fcnt !== 5'd16 || fmem[0] !== 8'h90) begin
            n_err++;
            $display("FAIL full_after: fcnt=%0d slot0=%h, want 16/90", fcnt, fmem[0]);
        end
        clear_inputs();
    endtask

    task automatic test_threshold();
        int eg;
        do_reset();
        drain          = 1'b1;
        fifo_threshold = 1'b1;
        req_valid      = 4'b0011;
        set_slice(0, 8'h50);
        set_slice(1, 8'h51);
        for (int c = 0; c < 6; c++) begin
            #1;
            eg = (c / 2) % 2;
            n_vec++;
            if (c % 2 == 0) begin
                if (fifo_wr !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL thr_bubble c%0d: wr=%b busy=%b, want 0/0", c, fifo_wr, busy);
                end
            end else begin
                if (fifo_wr !== 1'b1 || grant_id !== 2'(eg) || fifo_data !== 8'(8'h50 + eg)) begin
                    n_err++;
                    $display("FAIL thr_beat c%0d: wr=%b grant=%0d data=%h, want 1/%0d/%h",
                             c, fifo_wr, grant_id, fifo_data, eg, 8'(8'h50 + eg));
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int wrs;
        do_reset();
        drain     = 1'b1;
        req_valid = 4'b0010;
        set_slice(0, 8'h60);
        set_slice(1, 8'h61);
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (fifo_wr !== 1'b1 || grant_id !== 2'd1) begin
                n_err++;
                $display("FAIL mid_beat%0d: wr=%b grant=%0d, want 1/1", c, fifo_wr, grant_id);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (fifo_wr !== 1'b0 || req_ready !== 4'h0) begin
            n_err++;
            $display("FAIL mid_rst_gate: wr=%b ready=%h, want 0/0", fifo_wr, req_ready);
        end
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        #1;
        n_vec++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL mid_idle: busy=%b wr=%b grant=%0d, want 0/0/0", busy, fifo_wr, grant_id);
        end
        tick();
        #1;
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_data !== 8'h60) begin
            n_err++;
            $display("FAIL mid_regrant: busy=%b grant=%0d data=%h, want 1/0/60", busy, grant_id, fifo_data);
        end
        wrs = 0;
        for (int c = 0; c < 4; c++) begin
            if (fifo_wr && grant_id == 2'd0) wrs++;
            tick();
            #1;
        end
        n_vec++;
        if (wrs !== 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_full_burst: writes=%0d busy=%b, want 4/0", wrs, busy);
        end
        clear_inputs();
    endtask

    task automatic test_overflow();
        do_reset();
        fifo_overflow = 1'b1;
        #1;
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pre: err_ovf=%b want 0", err_ovf);
        end
        tick();
        fifo_overflow = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (err_ovf !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_sticky c%0d: err_ovf=%b want 1", c, err_ovf);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_cleared: err_ovf=%b want 0", err_ovf);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_threshold();
        test_reset_mid_burst();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
